i2c_bus_fabric: RTL and testbench
=================================

I2C_BUS_FABRIC -- requirements
Module: i2c_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_CTRL, default 3: number of controller driver pairs, legal range 1..16.
REQ-002 SHALL have parameter NUM_PERIPH, default 3: number of peripheral driver pairs, legal range 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: consecutive sampled SCL-low clk cycles while busy before a stuck-bus timeout is declared, legal range 2..2^20-1.
REQ-004 Ports SHALL be as follows (clock and reset first):
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_sda_drv  in  NUM_CTRL  per-controller SDA driver; 0 = pull low, 1 = release.
- ctrl_scl_drv  in  NUM_CTRL  per-controller SCL driver; same encoding.
- periph_sda_drv  in  NUM_PERIPH  per-peripheral SDA driver; same encoding.
- periph_scl_drv  in  NUM_PERIPH  per-peripheral SCL driver; same encoding.
- SDA_PIN  inout  1  physical open-drain data line.
- SCL_PIN  inout  1  physical open-drain clock line.
- sda_net  out  1  resolved SDA fed back to all devices.
- scl_net  out  1  resolved SCL fed back to all devices.
- bus_busy  out  1  high from START until STOP or timeout recovery.
- start_pulse  out  1  one-cycle pulse on START or repeated START.
- stop_pulse  out  1  one-cycle pulse on STOP.
- arb_lost  out  NUM_CTRL  sticky per-controller arbitration-lost flags.
- owner  out  $clog2(NUM_CTRL) (min 1)  index of the winning controller.
- owner_valid  out  1  owner field is meaningful.
- stuck_timeout  out  1  level; high while in TIMEOUT.

Function
REQ-005 SDA_PIN SHALL be driven 0 when any SDA driver bit is 0, and high-Z otherwise; SCL_PIN likewise.
REQ-006 sda_net SHALL be 0 when SDA_PIN reads 0, and 1 otherwise (including Z/X); combinational, so external devices on the pin participate in the wired-AND; SCL likewise.
REQ-007 Monitor SHALL register sda_net/scl_net into sda_q/scl_q plus one previous-sample stage; all detection uses registered samples.
REQ-008 START SHALL be detected when scl_q and the previous scl sample are both 1, the previous sda sample is 1, and sda_q is 0. start_pulse asserts on the following cycle.
REQ-009 STOP SHALL use the same condition with sda rising (0 to 1). START and STOP are mutually exclusive per cycle by construction.
REQ-010 State machine SHALL use the states IDLE, BUSY and TIMEOUT:
- IDLE to BUSY on START.
- BUSY to IDLE on STOP.
- BUSY to BUSY on repeated START, with start_pulse asserted.
- BUSY to TIMEOUT when the SCL-low counter equals TIMEOUT_CYCLES.
- TIMEOUT to IDLE on a cycle with sda_q = scl_q = 1 or on STOP; stop_pulse is still emitted if a STOP occurs.
REQ-011 bus_busy SHALL equal (state != IDLE).
REQ-012 The SCL-low counter SHALL behave as follows:
- Increments each BUSY cycle with scl_q = 0.
- Clears on scl_q = 1, START, or leaving BUSY.
- Saturates and never wraps.
REQ-013 active[i] SHALL be set in BUSY when ctrl_sda_drv[i] or ctrl_scl_drv[i] is 0. active, arb_lost and owner_valid clear on START, STOP and timeout entry.
REQ-014 arb_lost[i] SHALL be set on a sampled SCL rising edge (previous scl 0, scl_q 1) when active[i] = 1, the registered ctrl_sda_drv[i] = 1, and sda_q = 0. It is sticky until cleared per REQ-013.
REQ-015 owner SHALL be the lowest index i with active[i] and not arb_lost[i]. owner_valid is high when such an i exists; otherwise owner = 0. owner is registered.
REQ-016 A controller that has lost arbitration SHALL NOT be re-marked as winner until the next START.

Reset
REQ-017 On rst:
- state = IDLE, counter = 0.
- sda_q/scl_q and previous samples = 1, so no spurious edge is detected.
- All status outputs = 0.
- Pins/nets stay combinational on the driver inputs.
REQ-018 rst asserted mid-transaction SHALL abandon it silently, with no stop_pulse. A START is required to re-enter BUSY.

Structure
REQ-019 Package i2c_bus_pkg SHALL hold the state enum (IDLE/BUSY/TIMEOUT) and the default TIMEOUT_CYCLES constant.
REQ-020 Sub-module i2c_bus_monitor SHALL contain the sampling, START/STOP detection, FSM and timeout counter. The top level keeps the wired-AND resolution and the arbitration/owner logic.

Verification
REQ-021 Directed scenarios:
- Resolution: all drivers 1, then periph_sda_drv[2] = 0 -> sda_net = 0 and SDA_PIN = 0; release -> SDA_PIN = Z, sda_net = 1.
- START/STOP: C0 makes SDA fall with SCL high -> start_pulse 2 cycles later, bus_busy = 1; SDA rises with SCL high -> stop_pulse, bus_busy = 0 one cycle later.
- Arbitration: C0 and C1 send 0x42 and 0x2A after START -> at first differing bit (MSB-1) with C0 releasing, arb_lost = 2'b01, owner = 1, owner_valid = 1.
- Timeout: TIMEOUT_CYCLES = 8, START, then SCL held low -> stuck_timeout = 1 after 8 low samples; release both lines -> IDLE.
- Repeated START in BUSY -> start_pulse, bus_busy stays 1, arb_lost cleared.
- rst mid-byte -> all outputs 0 next cycle, no stop_pulse.

Source files
------------

// File: rtl/i2c_bus_pkg.sv
// Shared types and constants for the I2C bus fabric and its monitor.
package i2c_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TIMEOUT = 2'd2
    } bus_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;
    localparam int LOW_CNT_W              = 20;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Samples the resolved lines, detects START/STOP, tracks bus state and the stuck-SCL timeout.
// Events are decoded from registered samples; pulses and state land one cycle after decode. Never stalls.
module i2c_bus_monitor
    import i2c_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sda_net,
    input  logic       scl_net,
    output logic       sda_q,
    output logic       scl_q,
    output logic       scl_p,
    output logic       start_det,
    output logic       stop_det,
    output logic       timeout_enter,
    output bus_state_t state,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       bus_busy,
    output logic       stuck_timeout
);

    localparam logic [LOW_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LOW_CNT_W-1:0] TO_VAL  = LOW_CNT_W'(TIMEOUT_CYCLES);

    logic                 sda_p;
    bus_state_t           state_nxt;
    logic [LOW_CNT_W-1:0] low_cnt, low_cnt_nxt;

    assign start_det     = scl_q & scl_p & sda_p & ~sda_q;
    assign stop_det      = scl_q & scl_p & ~sda_p & sda_q;
    assign timeout_enter = (state == BUSY) && !start_det && !stop_det && (low_cnt == TO_VAL);
    assign bus_busy      = (state != IDLE);
    assign stuck_timeout = (state == TIMEOUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = BUSY;
            BUSY: begin
                if (stop_det)           state_nxt = IDLE;
                else if (timeout_enter) state_nxt = TIMEOUT;
            end
            TIMEOUT: if ((sda_q && scl_q) || stop_det) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter only survives while staying in BUSY with SCL low and no START.
    always_comb begin
        low_cnt_nxt = '0;
        if (state == BUSY && state_nxt == BUSY && !start_det && !scl_q) begin
            low_cnt_nxt = (low_cnt == CNT_MAX) ? low_cnt : low_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sda_q       <= 1'b1;
            scl_q       <= 1'b1;
            sda_p       <= 1'b1;
            scl_p       <= 1'b1;
            state       <= IDLE;
            low_cnt     <= '0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
        end else begin
            sda_q       <= sda_net;
            scl_q       <= scl_net;
            sda_p       <= sda_q;
            scl_p       <= scl_q;
            state       <= state_nxt;
            low_cnt     <= low_cnt_nxt;
            start_pulse <= start_det;
            stop_pulse  <= stop_det;
        end
    end

endmodule

// File: rtl/i2c_bus_fabric.sv
// Wired-AND I2C bus with START/STOP monitor, stuck-bus timeout and multi-controller arbitration tracking.
// Nets are combinational; status is registered (events visible two cycles after the line change). Never stalls.
module i2c_bus_fabric
    import i2c_bus_pkg::*;
#(
    parameter int  NUM_CTRL       = 3,
    parameter int  NUM_PERIPH     = 3,
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int OWNER_W        = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CTRL-1:0]   ctrl_sda_drv,
    input  logic [NUM_CTRL-1:0]   ctrl_scl_drv,
    input  logic [NUM_PERIPH-1:0] periph_sda_drv,
    input  logic [NUM_PERIPH-1:0] periph_scl_drv,
    inout  wire                   SDA_PIN,
    inout  wire                   SCL_PIN,
    output logic                  sda_net,
    output logic                  scl_net,
    output logic                  bus_busy,
    output logic                  start_pulse,
    output logic                  stop_pulse,
    output logic [NUM_CTRL-1:0]   arb_lost,
    output logic [OWNER_W-1:0]    owner,
    output logic                  owner_valid,
    output logic                  stuck_timeout
);

    logic                sda_wired, scl_wired;
    logic                sda_q, scl_q, scl_p;
    logic                start_det, stop_det, timeout_enter;
    logic                arb_clr, scl_rise;
    bus_state_t          state;
    logic [NUM_CTRL-1:0] active, active_nxt, arb_lost_nxt, ctrl_sda_q, cand;
    logic [OWNER_W-1:0]  owner_nxt;
    logic                owner_valid_nxt;

    assign sda_wired = &{ctrl_sda_drv, periph_sda_drv};
    assign scl_wired = &{ctrl_scl_drv, periph_scl_drv};
    assign SDA_PIN   = sda_wired ? 1'bz : 1'b0;
    assign SCL_PIN   = scl_wired ? 1'bz : 1'b0;

    // Off-chip devices may also pull the pin; anything other than a solid 0 reads as released.
    assign sda_net = sda_wired & (SDA_PIN !== 1'b0);
    assign scl_net = scl_wired & (SCL_PIN !== 1'b0);

    i2c_bus_monitor #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_monitor (
        .clk          (clk),
        .rst          (rst),
        .sda_net      (sda_net),
        .scl_net      (scl_net),
        .sda_q        (sda_q),
        .scl_q        (scl_q),
        .scl_p        (scl_p),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .timeout_enter(timeout_enter),
        .state        (state),
        .start_pulse  (start_pulse),
        .stop_pulse   (stop_pulse),
        .bus_busy     (bus_busy),
        .stuck_timeout(stuck_timeout)
    );

    assign arb_clr  = start_det | stop_det | timeout_enter;
    assign scl_rise = ~scl_p & scl_q;

    // ctrl_sda_q is aligned with sda_q, so a loss compares what a controller released against what the bus showed.
    always_comb begin
        active_nxt      = active;
        arb_lost_nxt    = arb_lost;
        owner_nxt       = '0;
        owner_valid_nxt = 1'b0;
        if (arb_clr) begin
            active_nxt   = '0;
            arb_lost_nxt = '0;
        end else begin
            if (state == BUSY) active_nxt = active | ~(ctrl_sda_drv & ctrl_scl_drv);
            if (scl_rise) arb_lost_nxt = arb_lost | (active & ctrl_sda_q & {NUM_CTRL{~sda_q}});
        end
        cand = active_nxt & ~arb_lost_nxt;
        for (int i = NUM_CTRL - 1; i >= 0; i--) begin
            if (cand[i]) begin
                owner_nxt       = OWNER_W'(i);
                owner_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_sda_q  <= '1;
            active      <= '0;
            arb_lost    <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
        end else begin
            ctrl_sda_q  <= ctrl_sda_drv;
            active      <= active_nxt;
            arb_lost    <= arb_lost_nxt;
            owner       <= owner_nxt;
            owner_valid <= owner_valid_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_bus_fabric.sv
// Bench for i2c_bus_fabric: directed scenarios plus random line wiggling against an event-level reference model.
module tb_i2c_bus_fabric;
    localparam int NC = 3;
    localparam int NP = 3;
    localparam int TO = 8;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] c_sda = '1;
    logic [NC-1:0] c_scl = '1;
    logic [NP-1:0] p_sda = '1;
    logic [NP-1:0] p_scl = '1;
    wire           sda_line, scl_line;
    logic          sda_net, scl_net, bus_busy, start_pulse, stop_pulse, owner_valid, stuck_timeout;
    logic [NC-1:0] arb_lost;
    logic [OW-1:0] owner;
    int            n_vec = 0;
    int            n_err = 0;

    pullup (sda_line);
    pullup (scl_line);

    always #5 clk = ~clk;

    i2c_bus_fabric #(.NUM_CTRL(NC), .NUM_PERIPH(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ctrl_sda_drv(c_sda), .ctrl_scl_drv(c_scl),
        .periph_sda_drv(p_sda), .periph_scl_drv(p_scl),
        .SDA_PIN(sda_line), .SCL_PIN(scl_line),
        .sda_net(sda_net), .scl_net(scl_net),
        .bus_busy(bus_busy), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .arb_lost(arb_lost), .owner(owner), .owner_valid(owner_valid),
        .stuck_timeout(stuck_timeout)
    );

    // Reference model: bus history as a queue of line samples (index 0 newest), bus phase as 0/1/2.
    int          m_st = 0;
    int          low_run = 0;
    bit          hist_sda[$] = '{1'b1, 1'b1};
    bit          hist_scl[$] = '{1'b1, 1'b1};
    bit [NC-1:0] m_act = '0, m_lost = '0, drv_prev = '1;
    bit          m_start = 0, m_stop = 0, m_ov = 0;
    bit [OW-1:0] m_owner = '0;

    always @(posedge clk) begin
        bit start_ev, stop_ev, rise, to_ev, in_busy;
        bit [NC-1:0] act_old;
        if (rst) begin
            m_st = 0; low_run = 0; m_act = '0; m_lost = '0; drv_prev = '1;
            m_start = 0; m_stop = 0;
            hist_sda = '{1'b1, 1'b1};
            hist_scl = '{1'b1, 1'b1};
        end else begin
            start_ev = hist_scl[0] && hist_scl[1] && hist_sda[1] && !hist_sda[0];
            stop_ev  = hist_scl[0] && hist_scl[1] && !hist_sda[1] && hist_sda[0];
            rise     = !hist_scl[1] && hist_scl[0];
            in_busy  = (m_st == 1);
            to_ev    = in_busy && !start_ev && !stop_ev && (low_run == TO);
            if (in_busy && !start_ev && !stop_ev && !to_ev && !hist_scl[0]) low_run++;
            else low_run = 0;
            if (m_st == 0 && start_ev) m_st = 1;
            else if (m_st == 1 && stop_ev) m_st = 0;
            else if (to_ev) m_st = 2;
            else if (m_st == 2 && ((hist_sda[0] && hist_scl[0]) || stop_ev)) m_st = 0;
            m_start = start_ev;
            m_stop  = stop_ev;
            act_old = m_act;
            if (start_ev || stop_ev || to_ev) begin
                m_act = '0; m_lost = '0;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (in_busy && (!c_sda[i] || !c_scl[i])) m_act[i] = 1'b1;
                    if (rise && act_old[i] && drv_prev[i] && !hist_sda[0]) m_lost[i] = 1'b1;
                end
            end
            drv_prev = c_sda;
            hist_sda.push_front(&{c_sda, p_sda});
            hist_scl.push_front(&{c_scl, p_scl});
            void'(hist_sda.pop_back());
            void'(hist_scl.pop_back());
        end
        m_ov = 0; m_owner = '0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (m_act[i] && !m_lost[i]) begin m_ov = 1; m_owner = OW'(i); end
        end
    end

    logic [11:0] obs_vec, exp_vec;
    assign obs_vec = {bus_busy, start_pulse, stop_pulse, stuck_timeout, owner_valid, owner, arb_lost, sda_net, scl_net};
    assign exp_vec = {m_st != 0, m_start, m_stop, m_st == 2, m_ov, m_owner, m_lost, &{c_sda, p_sda}, &{c_scl, p_scl}};

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hold(3);
        n_vec++;
        if ({bus_busy, start_pulse, stop_pulse, stuck_timeout, owner_valid, arb_lost, owner} !== '0) begin
            n_err++;
            $display("FAIL reset_status got=%b required=0", {bus_busy, start_pulse, stop_pulse, stuck_timeout, owner_valid, arb_lost, owner});
        end
        rst = 1'b0;
        hold(1);
        n_vec++;
        if (obs_vec !== exp_vec) begin
            n_err++;
            $display("FAIL reset_release got=%h required=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_resolution;
        #1;
        n_vec++;
        if (sda_net !== 1'b1 || sda_line !== 1'b1) begin
            n_err++; $display("FAIL res_idle got net=%b pin=%b required 1/1", sda_net, sda_line);
        end
        p_sda[2] = 1'b0;
        #1;
        n_vec++;
        if (sda_net !== 1'b0 || sda_line !== 1'b0) begin
            n_err++; $display("FAIL res_pull got net=%b pin=%b required 0/0", sda_net, sda_line);
        end
        p_sda[2] = 1'b1;
        p_scl[0] = 1'b0;
        #1;
        n_vec++;
        // A released pin is left to the pull-up.
        if (sda_net !== 1'b1 || sda_line !== 1'b1 || scl_net !== 1'b0 || scl_line !== 1'b0) begin
            n_err++; $display("FAIL res_release got sda=%b/%b scl=%b/%b required 1/1 0/0", sda_net, sda_line, scl_net, scl_line);
        end
        p_scl[0] = 1'b1;
        hold(1);
    endtask

    task automatic test_start_stop;
        c_sda[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL start_vec cyc=%0d got=%h required=%h", i, obs_vec, exp_vec); end
            n_vec++;
            if (start_pulse !== (i == 2) || bus_busy !== (i >= 2)) begin
                n_err++; $display("FAIL start_timing cyc=%0d got start=%b busy=%b required start=%b busy=%b", i, start_pulse, bus_busy, i == 2, i >= 2);
            end
        end
        c_sda[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (stop_pulse !== (i == 2) || bus_busy !== (i < 2)) begin
                n_err++; $display("FAIL stop_timing cyc=%0d got stop=%b busy=%b required stop=%b busy=%b", i, stop_pulse, bus_busy, i == 2, i < 2);
            end
        end
    endtask

    task automatic test_arbitration;
        logic [7:0] byte0, byte1;
        bit [1:0]   inplay;
        byte0 = 8'h42; byte1 = 8'h2A; inplay = 2'b11;
        c_sda[1:0] = 2'b00;
        hold(3);
        for (int k = 7; k >= 0; k--) begin
            for (int ph = 0; ph < 3; ph++) begin
                if (ph == 0) c_scl[1:0] = 2'b00;
                else if (ph == 1) c_sda[1:0] = {~inplay[1] | byte1[k], ~inplay[0] | byte0[k]};
                else c_scl[1:0] = 2'b11;
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    n_vec++;
                    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL arb_vec bit=%0d ph=%0d got=%h required=%h", k, ph, obs_vec, exp_vec); end
                end
            end
            for (int i = 0; i < 2; i++) if (inplay[i] && c_sda[i] && !sda_line) inplay[i] = 1'b0;
        end
        n_vec++;
        if (arb_lost !== 3'b001 || owner !== 2'd1 || owner_valid !== 1'b1) begin
            n_err++; $display("FAIL arb_result got lost=%b owner=%0d valid=%b required lost=001 owner=1 valid=1", arb_lost, owner, owner_valid);
        end
        c_scl[1:0] = 2'b00; hold(2);
        c_sda = 3'b101;      hold(2);
        c_scl = '1;          hold(3);
        c_sda = '1;          hold(3);
        n_vec++;
        if (arb_lost !== 3'b000 || owner_valid !== 1'b0 || bus_busy !== 1'b0) begin
            n_err++; $display("FAIL arb_cleared got lost=%b valid=%b busy=%b required 000/0/0", arb_lost, owner_valid, bus_busy);
        end
    endtask

    task automatic test_timeout;
        int first;
        first = 0;
        c_sda[0] = 1'b0; hold(3);
        c_scl[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL tmo_vec cyc=%0d got=%h required=%h", i, obs_vec, exp_vec); end
            if (stuck_timeout === 1'b1 && first == 0) first = i;
        end
        n_vec++;
        if (first != TO + 2 || bus_busy !== 1'b1) begin
            n_err++; $display("FAIL tmo_entry got cycle=%0d busy=%b required cycle=%0d busy=1", first, bus_busy, TO + 2);
        end
        c_sda[0] = 1'b1; c_scl[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (stuck_timeout !== (i < 2) || stop_pulse !== 1'b0) begin
                n_err++; $display("FAIL tmo_exit cyc=%0d got tmo=%b stop=%b required tmo=%b stop=0", i, stuck_timeout, stop_pulse, i < 2);
            end
        end
    endtask

    task automatic test_repeated_start;
        bit saw_start, dropped;
        saw_start = 0; dropped = 0;
        c_sda[1:0] = 2'b00; hold(3);
        c_scl[1:0] = 2'b00; hold(2);
        c_sda[1:0] = 2'b01; hold(2);
        c_scl[1:0] = 2'b11; hold(3);
        n_vec++;
        if (arb_lost !== 3'b001) begin n_err++; $display("FAIL rs_setup got lost=%b required 001", arb_lost); end
        c_scl[1:0] = 2'b00; hold(2);
        c_sda = '1;          hold(2);
        c_scl = '1;          hold(3);
        c_sda[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rs_vec cyc=%0d got=%h required=%h", i, obs_vec, exp_vec); end
            if (start_pulse === 1'b1) saw_start = 1;
            if (bus_busy !== 1'b1) dropped = 1;
        end
        n_vec++;
        if (!saw_start || dropped || arb_lost !== 3'b000) begin
            n_err++; $display("FAIL rs_result got start=%b busy_dropped=%b lost=%b required 1/0/000", saw_start, dropped, arb_lost);
        end
        c_scl[1] = 1'b0; hold(2);
        c_scl[1] = 1'b1; hold(3);
        c_sda[1] = 1'b1; hold(3);
    endtask

    task automatic test_reset_mid;
        bit saw_stop, saw_busy;
        saw_stop = 0; saw_busy = 0;
        c_sda[0] = 1'b0; hold(3);
        c_scl[0] = 1'b0; hold(2);
        c_sda[0] = 1'b1; hold(1);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus_busy, start_pulse, stop_pulse, stuck_timeout, owner_valid, arb_lost, owner} !== '0) begin
            n_err++; $display("FAIL rstmid_status got=%b required=0", {bus_busy, start_pulse, stop_pulse, stuck_timeout, owner_valid, arb_lost, owner});
        end
        rst = 1'b0;
        c_scl[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rstmid_vec cyc=%0d got=%h required=%h", i, obs_vec, exp_vec); end
            if (stop_pulse === 1'b1) saw_stop = 1;
            if (bus_busy === 1'b1) saw_busy = 1;
        end
        n_vec++;
        if (saw_stop || saw_busy) begin
            n_err++; $display("FAIL rstmid_after got stop=%b busy=%b required 0/0", saw_stop, saw_busy);
        end
    endtask

    task automatic test_random;
        int which;
        bit v;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) begin
                which = $urandom_range(0, 11);
                v = ($urandom_range(0, 7) != 0);
                if (which < 3)      c_sda[which] = v;
                else if (which < 6) c_scl[which - 3] = v;
                else if (which < 9) p_sda[which - 6] = v;
                else                p_scl[which - 9] = v;
            end
            @(negedge clk);
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL random_vec cyc=%0d got=%h required=%h", cyc, obs_vec, exp_vec); end
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_resolution();
        test_start_stop();
        test_arbitration();
        test_timeout();
        test_repeated_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
